// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and EX operand forwarding,
// with a post-reset flush window and saturating stall/flush performance counters.
module hazard_unit #(
   parameter int unsigned INIT_CYCLES = 2,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rs1_E,
   input  logic [4:0]       Rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic [1:0]       ResultSrc_E,
   input  logic             PCSrc_E,
   input  logic [4:0]       Rd_M,
   input  logic             RegWrite_M,
   input  logic [4:0]       Rd_W,
   input  logic             RegWrite_W,
   input  logic             CntClr,
   output logic             Stall_F,
   output logic             Stall_D,
   output logic             Flush_D,
   output logic             Flush_E,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic             Ready,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int unsigned   IW          = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int unsigned   INIT_LOAD_I = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;
   localparam logic [IW-1:0] INIT_LOAD   = IW'(INIT_LOAD_I);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           r_state, w_state_next;
   logic [IW-1:0]    r_init_cnt, w_init_cnt_next;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_run;
   logic             w_lw_stall;

   // Memory stage wins over Writeback; x0 is hardwired zero and never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic we_m, input logic [4:0] rd_w,
                                          input logic we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      w_state_next    = r_state;
      w_init_cnt_next = r_init_cnt;
      if (rst) begin
         w_state_next    = (INIT_CYCLES == 0) ? S_RUN : S_INIT;
         w_init_cnt_next = INIT_LOAD;
      end else if (r_state == S_INIT) begin
         if (r_init_cnt == '0) begin
            w_state_next = S_RUN;
         end else begin
            w_init_cnt_next = r_init_cnt - IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
   end

   assign w_run      = !rst && (r_state == S_RUN);
   assign w_lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                       ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

   always_comb begin
      Stall_F    = 1'b1;
      Stall_D    = 1'b0;
      Flush_D    = 1'b1;
      Flush_E    = 1'b1;
      ForwardA_E = 2'b00;
      ForwardB_E = 2'b00;
      Ready      = 1'b0;
      if (w_run) begin
         // A taken branch squashes Decode, so the load-use bubble is unnecessary.
         Stall_F    = w_lw_stall && !PCSrc_E;
         Stall_D    = w_lw_stall && !PCSrc_E;
         Flush_D    = PCSrc_E;
         Flush_E    = w_lw_stall || PCSrc_E;
         ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
         ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
         Ready      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || CntClr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (w_run) begin
         if (Stall_D && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (PCSrc_E && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a cycle-count/integer reference model.
module tb_hazard_unit;

   localparam int unsigned INIT_CYCLES = 2;
   localparam int unsigned CNT_W       = 4;
   localparam int          CMAX        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
   logic [1:0]       ResultSrc_E;
   logic             PCSrc_E, RegWrite_M, RegWrite_W, CntClr;
   logic             Stall_F, Stall_D, Flush_D, Flush_E, Ready;
   logic [1:0]       ForwardA_E, ForwardB_E;
   logic [CNT_W-1:0] StallCount, FlushCount;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: cycles of flush window still to go, and plain integer counters.
   int m_init_left = INIT_CYCLES;
   int m_stall     = 0;
   int m_flush     = 0;
   bit m_ready_now = 0;
   bit m_stall_now = 0;

   hazard_unit #(
      .INIT_CYCLES(INIT_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Rs1_D      (Rs1_D),
      .Rs2_D      (Rs2_D),
      .Rs1_E      (Rs1_E),
      .Rs2_E      (Rs2_E),
      .Rd_E       (Rd_E),
      .ResultSrc_E(ResultSrc_E),
      .PCSrc_E    (PCSrc_E),
      .Rd_M       (Rd_M),
      .RegWrite_M (RegWrite_M),
      .Rd_W       (Rd_W),
      .RegWrite_W (RegWrite_W),
      .CntClr     (CntClr),
      .Stall_F    (Stall_F),
      .Stall_D    (Stall_D),
      .Flush_D    (Flush_D),
      .Flush_E    (Flush_E),
      .ForwardA_E (ForwardA_E),
      .ForwardB_E (ForwardB_E),
      .Ready      (Ready),
      .StallCount (StallCount),
      .FlushCount (FlushCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
      if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      bit lw, br, ready;
      lw    = (ResultSrc_E == 2'b01) && (Rd_E != 0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
      br    = PCSrc_E;
      ready = !rst && (m_init_left == 0);
      m_ready_now = ready;
      m_stall_now = ready && lw && !br;
      if (ready) begin
         chk("m_stall_f", Stall_F, lw && !br);
         chk("m_stall_d", Stall_D, lw && !br);
         chk("m_flush_d", Flush_D, br);
         chk("m_flush_e", Flush_E, lw || br);
         chk("m_fwd_a", ForwardA_E, m_fwd(Rs1_E));
         chk("m_fwd_b", ForwardB_E, m_fwd(Rs2_E));
      end else begin
         chk("m_stall_f", Stall_F, 1);
         chk("m_stall_d", Stall_D, 0);
         chk("m_flush_d", Flush_D, 1);
         chk("m_flush_e", Flush_E, 1);
         chk("m_fwd_a", ForwardA_E, 0);
         chk("m_fwd_b", ForwardB_E, 0);
      end
      chk("m_ready", Ready, ready);
      chk("m_stall_cnt", StallCount, m_stall);
      chk("m_flush_cnt", FlushCount, m_flush);
   end

   // Inputs are stable from negedge to posedge, so the negedge decisions apply here.
   always @(posedge clk) begin
      if (rst) begin
         m_init_left = INIT_CYCLES;
         m_stall     = 0;
         m_flush     = 0;
      end else begin
         if (CntClr) begin
            m_stall = 0;
            m_flush = 0;
         end else if (m_ready_now) begin
            if (m_stall_now && m_stall < CMAX) m_stall++;
            if (PCSrc_E && m_flush < CMAX) m_flush++;
         end
         if (m_init_left > 0) m_init_left--;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
      ResultSrc_E = 0; PCSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0; CntClr = 0;
   endtask

   task automatic set_lw(input logic [4:0] rd);
      ResultSrc_E = 2'b01; Rd_E = rd; Rs2_D = 5'd7;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", Ready, 0);
         chk("rst_flush_e", Flush_E, 1);
         chk("rst_stall_f", Stall_F, 1);
         nxt();
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("init_ready", Ready, 0);
         chk("init_flush_d", Flush_D, 1);
         nxt();
      end
      @(negedge clk);
      chk("run_ready", Ready, 1);
      chk("run_flush_e", Flush_E, 0);
      chk("run_stall_f", Stall_F, 0);
      chk("run_stall_cnt", StallCount, 0);

      // Forwarding priority
      nxt();
      Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
      @(negedge clk); chk("fwd_mem", ForwardA_E, 2'b10);
      nxt(); RegWrite_M = 0;
      @(negedge clk); chk("fwd_wb", ForwardA_E, 2'b01);
      nxt(); Rs1_E = 0; Rd_M = 0; Rd_W = 0; RegWrite_M = 1;
      @(negedge clk); chk("fwd_x0", ForwardA_E, 2'b00);

      // Load-use
      nxt(); clear_in(); Rs2_E = 3; Rd_W = 3; RegWrite_W = 1; set_lw(5'd7);
      @(negedge clk);
      chk("lw_stall_f", Stall_F, 1);
      chk("lw_stall_d", Stall_D, 1);
      chk("lw_flush_e", Flush_E, 1);
      chk("lw_flush_d", Flush_D, 0);
      chk("lw_fwd_b", ForwardB_E, 2'b01);
      chk("lw_cnt0", StallCount, 0);
      nxt(); clear_in();
      @(negedge clk); chk("lw_cnt1", StallCount, 1);
      nxt(); set_lw(5'd0);
      @(negedge clk); chk("lw_x0_stall", Stall_D, 0);

      // Branch plus load-use
      nxt(); set_lw(5'd7); PCSrc_E = 1;
      @(negedge clk);
      chk("br_stall_f", Stall_F, 0);
      chk("br_stall_d", Stall_D, 0);
      chk("br_flush_d", Flush_D, 1);
      chk("br_flush_e", Flush_E, 1);
      nxt(); clear_in();
      @(negedge clk);
      chk("br_flush_cnt", FlushCount, 1);
      chk("br_stall_cnt", StallCount, 1);

      // Saturation and clear
      nxt(); set_lw(5'd7);
      for (int i = 0; i < 20; i++) nxt();
      @(negedge clk); chk("sat_stall_cnt", StallCount, 15);
      nxt(); CntClr = 1;
      nxt(); CntClr = 0;
      @(negedge clk); chk("clr_stall_cnt", StallCount, 0);

      // Mid-run reset
      for (int i = 0; i < 9; i++) nxt();
      @(negedge clk); chk("pre_rst_cnt", StallCount, 9);
      nxt(); rst = 1;
      @(negedge clk);
      chk("mid_rst_ready", Ready, 0);
      chk("mid_rst_flush_e", Flush_E, 1);
      chk("mid_rst_stall_d", Stall_D, 0);
      nxt(); rst = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid_init_ready", Ready, 0);
         chk("mid_init_cnt", StallCount, 0);
         nxt();
      end
      @(negedge clk);
      chk("resume_ready", Ready, 1);
      chk("resume_stall_d", Stall_D, 1);
      nxt();
      @(negedge clk); chk("resume_cnt", StallCount, 1);

      // Randomized traffic, checked by the model
      for (int i = 0; i < 3000; i++) begin
         nxt();
         Rs1_D = 5'($urandom_range(0, 3));
         Rs2_D = 5'($urandom_range(0, 3));
         Rs1_E = 5'($urandom_range(0, 3));
         Rs2_E = 5'($urandom_range(0, 3));
         Rd_E  = 5'($urandom_range(0, 3));
         Rd_M  = 5'($urandom_range(0, 3));
         Rd_W  = 5'($urandom_range(0, 3));
         ResultSrc_E = 2'($urandom_range(0, 3));
         PCSrc_E     = ($urandom_range(0, 3) == 0);
         RegWrite_M  = 1'($urandom_range(0, 1));
         RegWrite_W  = 1'($urandom_range(0, 1));
         CntClr      = ($urandom_range(0, 31) == 0);
         rst         = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller that drives the stall and flush inputs of the F/D and D/E pipeline registers.
- Flush_E is wired to the D/E register's clr input.
- Generates ALU operand forwarding selects for the Execute stage.
- Sequences a post-reset pipeline-flush window and keeps saturating stall and flush performance counters.

Parameters:
INIT_CYCLES, 2, number of cycles after reset release during which the pipeline is held flushed (0 = run immediately)
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Rs1_D  input  5  source register 1 of the instruction in Decode
Rs2_D  input  5  source register 2 of the instruction in Decode
Rs1_E  input  5  source register 1 in Execute
Rs2_E  input  5  source register 2 in Execute
Rd_E  input  5  destination register in Execute
ResultSrc_E  input  2  result select in Execute; 2'b01 = load
PCSrc_E  input  1  taken branch or jump resolved in Execute
Rd_M  input  5  destination register in Memory
RegWrite_M  input  1  Memory-stage write enable
Rd_W  input  5  destination register in Writeback
RegWrite_W  input  1  Writeback-stage write enable
CntClr  input  1  synchronous clear of both performance counters
Stall_F  output  1  hold PC
Stall_D  output  1  hold the F/D register
Flush_D  output  1  clear the F/D register
Flush_E  output  1  clear the D/E register
ForwardA_E  output  2  operand A select: 00 = register file, 10 = Memory-stage ALU result, 01 = Writeback result
ForwardB_E  output  2  operand B select, same encoding
Ready  output  1  1 when the FSM is in RUN
StallCount  output  CNT_W  stall cycles counted in RUN
FlushCount  output  CNT_W  taken-branch flushes counted in RUN

Behaviour:
- FSM states are INIT and RUN.
- Reset and INIT entry:
  - rst high forces the next state to INIT with load counter = INIT_CYCLES-1.
  - If INIT_CYCLES==0, rst high forces the next state directly to RUN.
  - rst high also forces both counters to 0.
- INIT progression:
  - Each cycle in INIT with counter==0 moves to RUN; otherwise the counter decrements.
  - After rst deasserts, INIT therefore lasts exactly INIT_CYCLES cycles.
- Outputs while rst is high or the state is INIT:
  - Stall_F=1, Stall_D=0, Flush_D=1, Flush_E=1.
  - ForwardA_E=ForwardB_E=00, Ready=0.
  - Counters do not increment.
- All hazard and forward outputs are combinational from the current inputs and state. Latency is 0 cycles; only the FSM and counters are registered.
- Forwarding (RUN only), operand A:
  - 10 if RegWrite_M && Rd_M!=0 && Rd_M==Rs1_E.
  - Otherwise 01 if RegWrite_W && Rd_W!=0 && Rd_W==Rs1_E.
  - Otherwise 00.
  - The Memory stage has priority over Writeback. x0 is never forwarded.
- Forwarding, operand B: identical rule using Rs2_E.
- Load-use hazard:
  - lwStall = (ResultSrc_E==01) && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D).
- Control hazard: Flush_D = PCSrc_E.
- RUN outputs:
  - Stall_F = Stall_D = lwStall && !PCSrc_E.
  - Flush_E = lwStall || PCSrc_E.
- Simultaneous load-use and taken branch: the branch wins.
  - No stall; Flush_D=1, Flush_E=1.
  - The Decode instruction is squashed, so no bubble is needed.
- Performance counters, each cycle in RUN:
  - StallCount increments when Stall_D=1.
  - FlushCount increments when PCSrc_E=1.
- Counter rules:
  - Both counters saturate at all-ones and never wrap.
  - CntClr zeroes both counters and takes priority over an increment in the same cycle.
  - rst takes priority over CntClr.
- Reset mid-operation: on the next edge the FSM enters INIT (or RUN if INIT_CYCLES==0) and the counters clear. Flush outputs assert in the same cycle that rst is high.

Test Plan:
- Reset and INIT window: rst high 3 cycles, then low, INIT_CYCLES=2.
  - Flush_D=Flush_E=Stall_F=1 and Ready=0 while rst is high and for 2 cycles after release.
  - Cycle 3: Ready=1, all flush/stall outputs 0, StallCount=0.
- Forward priority: Rs1_E=5, Rd_M=5, RegWrite_M=1, Rd_W=5, RegWrite_W=1 -> ForwardA_E=10.
  - Then drop RegWrite_M -> ForwardA_E=01.
  - Set Rs1_E=Rd_M=Rd_W=0 -> ForwardA_E=00.
- Load-use: ResultSrc_E=01, Rd_E=7, Rs2_D=7 for 1 cycle.
  - Stall_F=Stall_D=Flush_E=1, Flush_D=0, ForwardB_E unaffected.
  - StallCount goes from 0 to 1.
  - Repeat with Rd_E=0 -> no stall.
- Branch plus load-use in the same cycle: PCSrc_E=1 with the load-use condition true.
  - Stall_F=Stall_D=0, Flush_D=Flush_E=1.
  - FlushCount +1, StallCount unchanged.
- Saturation and clear: CNT_W=4, hold the load-use condition 20 cycles.
  - StallCount reaches 15 and stays at 15.
  - CntClr=1 together with the stall -> next cycle StallCount=0.
- Mid-run reset: after StallCount=9, pulse rst for 1 cycle.
  - Counters=0, Ready=0 for INIT_CYCLES cycles, then resumes.
